// File: rtl/instr_prefetch_buffer.sv
// Sequential instruction prefetcher: fetches 8-bit codes over a req/ack port
// into a small FIFO, with flush/redirect that drops buffered and in-flight data.
module instr_prefetch_buffer #(
    parameter int DEPTH    = 4,
    parameter int PC_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    output logic                    mem_req_o,
    output logic [PC_WIDTH-1:0]     mem_addr_o,
    input  logic                    mem_ack_i,
    input  logic [7:0]              mem_rdata_i,
    output logic                    instr_valid_o,
    input  logic                    instr_ready_i,
    output logic [7:0]              instr_code_o,
    output logic [PC_WIDTH-1:0]     instr_pc_o,
    input  logic                    flush_i,
    input  logic [PC_WIDTH-1:0]     flush_pc_i,
    output logic [$clog2(DEPTH):0]  occupancy_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

    state_e                        state_q, state_d;
    logic [PC_WIDTH-1:0]           fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]           disc_addr_q, disc_addr_d;
    logic [AW-1:0]                 wr_ptr_q, rd_ptr_q;
    logic [AW:0]                   occ_q, occ_d;
    logic [DEPTH-1:0][7:0]         code_q;
    logic [DEPTH-1:0][PC_WIDTH-1:0] pc_q;
    logic                          push, pop, has_room;

    assign instr_valid_o = (occ_q != '0);
    assign occupancy_o   = occ_q;
    assign instr_code_o  = instr_valid_o ? code_q[rd_ptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? pc_q[rd_ptr_q] : '0;
    assign mem_req_o     = (state_q != IDLE);
    // While discarding, the stale request keeps its address even though
    // fetch_pc has already been redirected.
    assign mem_addr_o    = (state_q == DISCARD) ? disc_addr_q : fetch_pc_q;

    assign push     = (state_q == REQ) && mem_ack_i && !flush_i;
    assign pop      = instr_valid_o && instr_ready_i && !flush_i;
    assign occ_d    = flush_i ? '0 : occ_q + (AW+1)'(push) - (AW+1)'(pop);
    assign has_room = (occ_d < FULL);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        disc_addr_d = disc_addr_q;
        if (flush_i) begin
            fetch_pc_d = flush_pc_i;
            unique case (state_q)
                IDLE:    state_d = REQ;
                REQ: begin
                    if (!mem_ack_i) begin
                        state_d     = DISCARD;
                        disc_addr_d = fetch_pc_q;
                    end
                end
                DISCARD: if (mem_ack_i) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end else begin
            unique case (state_q)
                IDLE:    if (has_room) state_d = REQ;
                REQ: begin
                    if (mem_ack_i) begin
                        fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
                        if (!has_room) state_d = IDLE;
                    end
                end
                DISCARD: if (mem_ack_i) state_d = REQ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            fetch_pc_q  <= '0;
            disc_addr_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            code_q      <= '0;
            pc_q        <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            disc_addr_q <= disc_addr_d;
            occ_q       <= occ_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) begin
                    code_q[wr_ptr_q] <= mem_rdata_i;
                    pc_q[wr_ptr_q]   <= fetch_pc_q;
                    wr_ptr_q         <= wr_ptr_q + 1'b1;
                end
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Randomized scoreboard bench for instr_prefetch_buffer with directed scenarios.
module tb_instr_prefetch_buffer;
    localparam int DEPTH = 4;

    logic       clk = 1'b0, reset_n = 1'b0;
    logic       mem_req, mem_ack, instr_valid, instr_ready, flush;
    logic [7:0] mem_addr, mem_rdata, instr_code, instr_pc, flush_pc;
    logic [2:0] occupancy;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.DEPTH(DEPTH), .PC_WIDTH(8)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_code_o(instr_code), .instr_pc_o(instr_pc),
        .flush_i(flush), .flush_pc_i(flush_pc),
        .occupancy_o(occupancy)
    );

    typedef struct packed { logic [7:0] code; logic [7:0] pc; } item_t;

    int n_cmp = 0, n_bad = 0;
    item_t q[$];
    item_t e;
    logic [7:0] exp_pc, stale_addr, prev_addr, salt;
    bit stale, prev_req, prev_ack;
    int wait_cnt, ack_min, ack_max;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_pc = 8'h00; stale = 0; prev_req = 0; prev_ack = 0; wait_cnt = 0;
    endtask

    // Called once per cycle just after the rising edge: check, then drive.
    task automatic drive(input bit rdy, input bit fl, input logic [7:0] fpc);
        bit req, ack;
        logic [7:0] addr;
        req  = mem_req;
        addr = mem_addr;
        check("occupancy", occupancy, q.size());
        check("instr_valid", instr_valid, q.size() != 0);
        if (q.size() == 0) begin
            check("empty_code", instr_code, 0);
            check("empty_pc", instr_pc, 0);
        end
        check("mem_req", req, stale || q.size() < DEPTH);
        if (prev_req && !prev_ack) check("addr_hold", addr, prev_addr);
        if (req) check("mem_addr", addr, stale ? stale_addr : exp_pc);
        ack = 0;
        if (req) begin
            if (!(prev_req && !prev_ack)) wait_cnt = $urandom_range(ack_max, ack_min);
            if (wait_cnt == 0) ack = 1; else wait_cnt--;
        end
        mem_ack     = ack;
        mem_rdata   = ack ? (addr ^ salt) : 8'($urandom);
        instr_ready = rdy;
        flush       = fl;
        flush_pc    = fpc;
        if (ack) begin
            if (stale) stale = 0;
            else if (!fl) begin
                q.push_back({exp_pc ^ salt, exp_pc});
                exp_pc = exp_pc + 8'h01;
            end
        end
        if (fl) begin
            q.delete();
            if (req && !ack && !stale) begin
                stale = 1;
                stale_addr = addr;
            end
            exp_pc = fpc;
        end
        prev_req = req; prev_addr = addr; prev_ack = ack;
    endtask

    task automatic cyc(input bit rdy, input bit fl, input logic [7:0] fpc);
        @(posedge clk); #1;
        drive(rdy, fl, fpc);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        mem_ack = 0; mem_rdata = 0; instr_ready = 0; flush = 0; flush_pc = 0;
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset_n && instr_valid && instr_ready && !flush) begin
            if (q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL pop_unexpected: got pc %0h, expected none", instr_pc);
            end else begin
                e = q.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr_code", instr_code, e.code);
            end
        end
    end

    initial begin
        mem_ack = 0; mem_rdata = 0; instr_ready = 0; flush = 0; flush_pc = 0;
        salt = 8'hA5; ack_min = 0; ack_max = 0;
        model_reset();
        #12;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_valid", instr_valid, 0);
        check("rst_code", instr_code, 0);
        check("rst_pc", instr_pc, 0);
        check("rst_occ", occupancy, 0);
        @(negedge clk); reset_n = 1'b1;

        // In-order delivery with immediate acks and always-ready consumer
        repeat (8) cyc(1, 0, 0);

        // Back-pressure: fill to DEPTH, stall, then a single pop refetches addr 4
        do_reset();
        repeat (8) cyc(0, 0, 0);
        cyc(1, 0, 0);
        repeat (4) cyc(0, 0, 0);

        // Flush during a slow request: stale ack dropped, refetch at 0x40
        do_reset();
        ack_min = 3; ack_max = 3;
        cyc(1, 1, 8'h40);
        repeat (12) cyc(1, 0, 0);

        // PC wrap after redirect to 0xFF
        ack_min = 0; ack_max = 0;
        cyc(1, 1, 8'hFF);
        repeat (6) cyc(1, 0, 0);

        // Flush + ack + pop in the same cycle at occupancy 2
        do_reset();
        repeat (2) cyc(0, 0, 0);
        cyc(1, 1, 8'h30);
        repeat (3) cyc(0, 0, 0);

        // Async reset mid-request at occupancy 3; late ack must be ignored
        do_reset();
        repeat (3) cyc(0, 0, 0);
        @(posedge clk); #2;
        check("pre_rst_occ", occupancy, 3);
        reset_n = 1'b0;
        mem_ack = 1'b1; mem_rdata = 8'h77; instr_ready = 0; flush = 0;
        #1;
        check("async_rst_req", mem_req, 0);
        check("async_rst_valid", instr_valid, 0);
        check("async_rst_occ", occupancy, 0);
        model_reset();
        @(negedge clk); reset_n = 1'b1;
        repeat (6) cyc(1, 0, 0);

        // Randomized traffic with varying back-pressure, latency and flushes
        do_reset();
        ack_min = 0; ack_max = 3;
        for (int ph = 0; ph < 4; ph++) begin
            salt = 8'($urandom);
            for (int i = 0; i < 600; i++)
                cyc($urandom_range(0, 3) > ph[1:0] - 2'd1 ? 1'b1 : ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 39) == 0, 8'($urandom));
        end
        repeat (10) cyc(1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
